stereo_magnitude_serializer: RTL
================================

# stereo_magnitude_serializer

Converts one signed stereo PCM pair per input beat into two unsigned magnitude beats, left then right, each tagged with a channel flag. Sits directly upstream of the per-channel section-maximum stage in the level-meter chain. Its output `o_is_left`/`o_value` pair drives that stage's channel-select and value inputs. It absorbs output backpressure with a one-pair holding register.

## Interface
- `width`, default 16: input sample width, two's complement. Output magnitude width is `width-1`.
- `clk` input 1: single clock, rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `i_valid` input 1: stereo pair present.
- `i_ready` output 1: pair accepted on `i_valid && i_ready`.
- `i_left` input `width`: signed left sample.
- `i_right` input `width`: signed right sample.
- `o_valid` output 1: magnitude beat present.
- `o_ready` input 1: beat consumed on `o_valid && o_ready`.
- `o_is_left` output 1: 1 = left-channel beat, 0 = right-channel beat.
- `o_value` output `width-1`: unsigned magnitude.
- `o_clip` output 1: present only with the macro; see Configuration.

## Operation
- Magnitude rule:
  - Non-negative x gives x.
  - Negative x gives −x.
  - The most-negative value (−2^(width−1), 0x8000 at width 16) saturates to 2^(width−1)−1 (0x7FFF).
- Both magnitudes are computed on acceptance and stored in a pair register (`mag_l`, `mag_r`). Raw samples are not retained.
- State machine, states EMPTY, LEFT, RIGHT:
  - EMPTY: `o_valid`=0. A handshake stores the pair and moves to LEFT.
  - LEFT: `o_valid`=1, `o_is_left`=1, `o_value`=`mag_l`. `o_ready` moves to RIGHT.
  - RIGHT: `o_valid`=1, `o_is_left`=0, `o_value`=`mag_r`.
    - `o_ready` && `i_valid`: store the new pair and move to LEFT.
    - `o_ready` && !`i_valid`: move to EMPTY.
    - !`o_ready`: hold.
- `i_ready` = (state==EMPTY) || (state==RIGHT && `o_ready`).
- Outputs hold stable while `o_valid` && !`o_ready`. The beat is never withdrawn.
- Beat order is always strictly L, R, L, R. No pair is split, dropped or duplicated.

## Timing
- Reset (async assert, sync deassert by system): state EMPTY, `mag_l`=`mag_r`=0, `o_valid`=0, `o_is_left`=0, `o_value`=0, `o_clip`=0, `i_ready`=1.
- Reset mid-pair discards the pending beats. The first post-reset output beat is always a left beat.
- Latency: pair accepted at edge N; the left beat is valid from N+1, the right beat from N+2 if `o_ready` is held at 1.
- Sustained throughput: one pair per 2 cycles with `o_ready`=1. Back-to-back reload happens in RIGHT without passing through EMPTY.
- `o_valid`, `o_is_left`, `o_value` and `o_clip` depend only on registers. There is no combinational path from `i_*` to `o_*`.
- `i_ready` depends combinationally on `o_ready` in RIGHT only.
- When `o_ready` is tied to 1 (as by the section-maximum stage), `i_ready` is high in EMPTY and RIGHT and low in LEFT.

## Configuration
- Macro `STEREO_MAGNITUDE_CLIP_FLAG_EN`.
- Defined:
  - The `o_clip` port exists.
  - Clip bits are stored per channel on acceptance: set when the sample equals the most-positive or most-negative code.
  - `o_clip` is presented alongside the matching beat. Reset value 0.
- Undefined: no `o_clip` port and no clip registers. All other behaviour is identical.

## Structure
- Package `stereo_magnitude_pkg` contains:
  - the state enum `state_t` (EMPTY, LEFT, RIGHT);
  - the `width` default as a localparam, shared with the section-maximum stage so both agree on a magnitude width of `width`−1.
- One combinational sub-module, `magnitude_abs`, instantiated twice (L, R):
  - parameter `width`;
  - input x[`width`−1:0];
  - outputs mag[`width`−2:0] and is_full_scale.

## Test plan
- Reset, then pair L=0x0005, R=0xFFFB, `o_ready`=1: beats (is_left=1, value 5) then (is_left=0, value 5), then `o_valid`=0. `i_ready` is back to 1 after the right beat.
- L=0x8000, R=0x7FFF: both beats give value 0x7FFF. With the macro, `o_clip`=1 on both beats. L=0x0001 gives `o_clip`=0.
- Continuous `i_valid` with incrementing pairs and `o_ready`=1: one pair accepted every 2 cycles, gap-free output, strict L/R alternation, no loss.
- `o_ready` held 0 for 5 cycles in LEFT: `o_value` and `o_is_left` stable, `i_ready`=0 throughout. On release, the right beat follows and the next pair is accepted in the same cycle it is consumed.
- `reset_n` asserted while in RIGHT with a pair pending: `o_valid`=0 immediately (asynchronously). After release, a new pair L=0x0010, R=0x0020 yields 0x10 first with `o_is_left`=1.
- Random `i_valid`/`o_ready` over 10k cycles against a reference model: output sequence equals the per-pair L, R magnitude sequence exactly.

Source files
------------

// File: rtl/stereo_magnitude_pkg.sv
// Shared types and widths for the level-meter chain.
// Magnitude width downstream is default_width-1.
package stereo_magnitude_pkg;

  localparam int default_width = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } state_t;

endpackage

// File: rtl/magnitude_abs.sv
// Saturating absolute value of a two's complement sample.
// Also flags samples at either full-scale code.
module magnitude_abs #(
  parameter int width = 16
) (
  input  logic [width-1:0] x,
  output logic [width-2:0] mag,
  output logic             is_full_scale
);

  localparam logic [width-1:0] most_neg = {1'b1, {(width-1){1'b0}}};
  localparam logic [width-1:0] most_pos = ~most_neg;

  logic [width-1:0] neg;

  assign neg = '0 - x;

  // -most_neg does not fit, so it clamps to the largest magnitude
  assign mag = (x == most_neg) ? most_pos[width-2:0] :
               x[width-1]      ? neg[width-2:0]      :
                                 x[width-2:0];

  assign is_full_scale = (x == most_neg) || (x == most_pos);

endmodule

// File: rtl/stereo_magnitude_serializer.sv
// Stereo pair -> L,R magnitude beats with a one-pair holding register.
// Define STEREO_MAGNITUDE_CLIP_FLAG_EN to add the o_clip output.
module stereo_magnitude_serializer
  import stereo_magnitude_pkg::*;
#(
  parameter int width = default_width
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_valid,
  output logic             i_ready,
  input  logic [width-1:0] i_left,
  input  logic [width-1:0] i_right,
  output logic             o_valid,
  input  logic             o_ready,
  output logic             o_is_left,
`ifdef STEREO_MAGNITUDE_CLIP_FLAG_EN
  output logic             o_clip,
`endif
  output logic [width-2:0] o_value
);

  state_t           state;
  logic [width-2:0] abs_l;
  logic [width-2:0] abs_r;
  logic [width-2:0] mag_l;
  logic [width-2:0] mag_r;
  logic             accept;

  assign i_ready = (state == EMPTY) ||
                   ((state == RIGHT) && o_ready);
  assign accept  = i_valid && i_ready;

`ifdef STEREO_MAGNITUDE_CLIP_FLAG_EN
  logic fs_l;
  logic fs_r;
  logic clip_l;
  logic clip_r;

  magnitude_abs #(.width(width)) u_abs_l (
    .x(i_left), .mag(abs_l), .is_full_scale(fs_l)
  );
  magnitude_abs #(.width(width)) u_abs_r (
    .x(i_right), .mag(abs_r), .is_full_scale(fs_r)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clip_l <= 1'b0;
      clip_r <= 1'b0;
      o_clip <= 1'b0;
    end else if (accept) begin
      clip_l <= fs_l;
      clip_r <= fs_r;
      o_clip <= fs_l;
    end else if (o_ready && state == LEFT) begin
      o_clip <= clip_r;
    end
  end
`else
  magnitude_abs #(.width(width)) u_abs_l (
    .x(i_left), .mag(abs_l), .is_full_scale()
  );
  magnitude_abs #(.width(width)) u_abs_r (
    .x(i_right), .mag(abs_r), .is_full_scale()
  );
`endif

  // Reload in RIGHT goes straight to LEFT, keeping 1 pair / 2 cycles
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= EMPTY;
      mag_l     <= '0;
      mag_r     <= '0;
      o_valid   <= 1'b0;
      o_is_left <= 1'b0;
      o_value   <= '0;
    end else if (accept) begin
      state     <= LEFT;
      mag_l     <= abs_l;
      mag_r     <= abs_r;
      o_valid   <= 1'b1;
      o_is_left <= 1'b1;
      o_value   <= abs_l;
    end else if (o_ready) begin
      case (state)
        LEFT: begin
          state     <= RIGHT;
          o_is_left <= 1'b0;
          o_value   <= mag_r;
        end
        RIGHT: begin
          state     <= EMPTY;
          o_valid   <= 1'b0;
          o_is_left <= 1'b0;
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule
